// File: rtl/ibex_ibus_arbiter.sv
// Two-port instruction-bus arbiter with in-order response routing back to the requesting port.
// Define IBEX_IBUS_ARB_RR_EN for round-robin arbitration instead of fixed priority with a starvation guard.
module ibex_ibus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 8,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p0_req_i,
  input  logic [31:0] p0_addr_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic [31:0] p1_addr_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic        p1_err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o,
  output logic        unexpected_rvalid_o
);

  localparam int unsigned CntW = 3;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic [31:0]               hold_addr_q;
  logic [CntW-1:0]           count_q, count_d, wr_idx;
  logic [MaxOutstanding-1:0] ids_q, ids_d;

  logic        slot_free, any_req, winner, owner_req, capture;
  logic        mem_req, gnt_id, push, pop;
  logic [31:0] winner_addr, req_addr;

  assign slot_free   = count_q < CntW'(MaxOutstanding);
  assign any_req     = p0_req_i | p1_req_i;
  assign owner_req   = owner_q ? p1_req_i : p0_req_i;
  assign winner_addr = winner ? p1_addr_i : p0_addr_i;

`ifdef IBEX_IBUS_ARB_RR_EN
  // Round-robin: on contention the port that was not granted last wins
  logic last_q, last_d;

  assign winner = p1_req_i & (~p0_req_i | ~last_q);
  assign last_d = push ? gnt_id : last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  // Fixed priority to port 0, overridden once port 1 has waited StarveLimit cycles
  localparam int unsigned StarveW = 8;
  logic [StarveW-1:0] starve_q, starve_d;

  assign winner = p1_req_i & (~p0_req_i | (starve_q == StarveW'(StarveLimit)));

  always_comb begin
    starve_d = starve_q;
    if (!p1_req_i || p1_gnt_o)                     starve_d = '0;
    else if (starve_q != StarveW'(StarveLimit))    starve_d = starve_q + StarveW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q == IDLE) begin
      if (slot_free && any_req && !mem_gnt_i) begin
        state_d = HOLD;
        owner_d = winner;
      end
    end else if (mem_gnt_i || !owner_req) begin
      state_d = IDLE;
    end
  end

  // FSM outputs
  always_comb begin
    mem_req  = 1'b0;
    gnt_id   = winner;
    req_addr = winner_addr;
    if (state_q == IDLE) begin
      mem_req = slot_free & any_req;
    end else begin
      mem_req  = owner_req;
      gnt_id   = owner_q;
      req_addr = hold_addr_q;
    end
  end

  assign capture = (state_q == IDLE) && (state_d == HOLD);

  // Address of a stalled request is held for the whole HOLD phase
  if (ResetAll) begin : g_addr_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      hold_addr_q <= '0;
      else if (capture) hold_addr_q <= winner_addr;
    end
  end else begin : g_addr_norst
    always_ff @(posedge clk_i) begin
      if (capture) hold_addr_q <= winner_addr;
    end
  end

  assign push = mem_req & mem_gnt_i;
  assign pop  = mem_rvalid_i & (count_q != '0);

  // In-order ID queue: head at bit 0, pop shifts the queue down
  always_comb begin
    ids_d   = ids_q;
    wr_idx  = count_q - CntW'(pop);
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (pop) ids_d = ids_q >> 1;
    for (int unsigned i = 0; i < MaxOutstanding; i++) begin
      if (push && (wr_idx == CntW'(i))) ids_d[i] = gnt_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ids_q   <= '0;
    end else begin
      count_q <= count_d;
      ids_q   <= ids_d;
    end
  end

  assign mem_req_o           = mem_req;
  assign mem_addr_o          = mem_req ? (req_addr & 32'hFFFF_FFFC) : 32'h0;
  assign p0_gnt_o            = push & ~gnt_id;
  assign p1_gnt_o            = push & gnt_id;
  assign p0_rvalid_o         = pop & ~ids_q[0];
  assign p1_rvalid_o         = pop & ids_q[0];
  assign p0_err_o            = p0_rvalid_o & mem_err_i;
  assign p1_err_o            = p1_rvalid_o & mem_err_i;
  assign rdata_o             = mem_rdata_i;
  assign busy_o              = (count_q != '0) | mem_req;
  assign unexpected_rvalid_o = mem_rvalid_i & (count_q == '0);

endmodule
